// File: rtl/layer_sequencer.sv
// Layer sequencer: steps through a descriptor table, loading each layer's
// configuration and handshaking with the issue unit through reset/done.
//
// state | meaning
// IDLE  | waiting for start; descriptor table writable
// LOAD  | read descriptor[layer_idx] and validate it
// RESET | hold issue unit in reset for two cycles
// RUN   | issue unit active; count cycles until issue_done
// NEXT  | advance layer_idx, pick LOAD or DONE
// DONE  | one-cycle all_done pulse
module layer_sequencer #(
  parameter int MAX_LAYERS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0]   cfg_addr,
  input  logic [21:0]                     cfg_data,
  input  logic [$clog2(MAX_LAYERS):0]     num_layers,
  input  logic                            start,
  input  logic                            issue_done,
  output logic                            issue_rst,
  output logic [7:0]                      image_dim,
  output logic [8:0]                      image_depth,
  output logic [1:0]                      filter_halfsize,
  output logic [2:0]                      filter_stride,
  output logic [$clog2(MAX_LAYERS):0]     layer_idx,
  output logic                            busy,
  output logic                            all_done,
  output logic                            error,
  output logic [23:0]                     last_layer_cycles
);

  localparam int AW = $clog2(MAX_LAYERS);
  localparam int LW = AW + 1;
  localparam logic [AW:0] MAX_L = MAX_LAYERS[AW:0];

  typedef enum logic [2:0] {
    IDLE, LOAD, RESET, RUN, NEXT, DONE
  } state_t;

  state_t state, state_d;

  logic [21:0]   table_q [MAX_LAYERS];
  logic [21:0]   desc;
  logic [7:0]    d_dim;
  logic [8:0]    d_depth;
  logic [1:0]    d_half;
  logic [2:0]    d_stride;
  logic          desc_ok;
  logic [AW:0]   num_lat;
  logic          rst_cnt;
  logic [23:0]   run_cnt;
  logic [23:0]   cnt_inc;
  logic          stale;
  logic          done_ok;

  assign desc     = table_q[layer_idx[AW-1:0]];
  assign d_dim    = desc[21:14];
  assign d_depth  = desc[13:5];
  assign d_half   = desc[4:3];
  assign d_stride = desc[2:0];

  // Largest legal stride is 2*halfsize+1, which is {halfsize,1} in 3 bits.
  assign desc_ok = (d_dim >= 8'd13) && (d_dim <= 8'd224) &&
                   (d_depth >= 9'd1) && (d_depth <= 9'd384) &&
                   ((d_half == 2'd1) || (d_half == 2'd2)) &&
                   (d_stride >= 3'd1) && (d_stride <= {d_half, 1'b1});

  assign cnt_inc = (&run_cnt) ? run_cnt : run_cnt + 24'd1;

  // A done still held from the previous layer is masked until it drops.
  assign done_ok = (state == RUN) && issue_done && !stale;

  assign issue_rst = (state != RUN);
  assign busy      = (state != IDLE);
  assign all_done  = (state == DONE);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = (num_layers == '0) ? DONE : LOAD;
      LOAD:    state_d = desc_ok ? RESET : DONE;
      RESET:   if (rst_cnt) state_d = RUN;
      RUN:     if (done_ok) state_d = NEXT;
      NEXT:    state_d = ((layer_idx + LW'(1)) == num_lat) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cfg_we && (state == IDLE)) table_q[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      num_lat           <= '0;
      layer_idx         <= '0;
      image_dim         <= '0;
      image_depth       <= '0;
      filter_halfsize   <= '0;
      filter_stride     <= '0;
      error             <= 1'b0;
      rst_cnt           <= 1'b0;
      run_cnt           <= '0;
      last_layer_cycles <= '0;
      stale             <= 1'b0;
    end else begin
      state <= state_d;
      if (!issue_done) stale <= 1'b0;
      else if (done_ok) stale <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            num_lat   <= (num_layers > MAX_L) ? MAX_L : num_layers;
            error     <= 1'b0;
            layer_idx <= '0;
          end
        end
        LOAD: begin
          image_dim       <= d_dim;
          image_depth     <= d_depth;
          filter_halfsize <= d_half;
          filter_stride   <= d_stride;
          rst_cnt         <= 1'b0;
          if (!desc_ok) error <= 1'b1;
        end
        RESET: begin
          rst_cnt <= ~rst_cnt;
          run_cnt <= '0;
        end
        RUN: begin
          run_cnt <= cnt_inc;
          if (done_ok) last_layer_cycles <= cnt_inc;
        end
        NEXT: layer_idx <= layer_idx + LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: linear stimulus, immediate assertions
// against hand-computed values.
module tb_layer_sequencer;
  logic        clk = 1'b0;
  logic        rst, cfg_we, start, issue_done;
  logic [2:0]  cfg_addr;
  logic [21:0] cfg_data;
  logic [3:0]  num_layers;
  logic        issue_rst, busy, all_done, error;
  logic [7:0]  image_dim;
  logic [8:0]  image_depth;
  logic [1:0]  filter_halfsize;
  logic [2:0]  filter_stride;
  logic [3:0]  layer_idx;
  logic [23:0] last_layer_cycles;

  int n_cmp = 0, n_err = 0;
  int n_pulse = 0, n_busy = 0, n_run = 0;
  int p0, b0, r0;

  layer_sequencer #(.MAX_LAYERS(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_layers(num_layers), .start(start),
    .issue_done(issue_done), .issue_rst(issue_rst), .image_dim(image_dim),
    .image_depth(image_depth), .filter_halfsize(filter_halfsize),
    .filter_stride(filter_stride), .layer_idx(layer_idx), .busy(busy),
    .all_done(all_done), .error(error), .last_layer_cycles(last_layer_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (all_done === 1'b1) n_pulse <= n_pulse + 1;
    if (busy === 1'b1) n_busy <= n_busy + 1;
    if (issue_rst === 1'b0) n_run <= n_run + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [21:0] mk_desc(int dim, int depth, int half, int stride);
    return {8'(dim), 9'(depth), 2'(half), 3'(stride)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [21:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick;
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] n);
    num_layers = n; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Called in LOAD; counts issue_rst-high cycles until RUN (expect 3).
  task automatic enter_run(input string tag);
    int c = 0;
    while (issue_rst === 1'b1 && c < 50) begin
      tick;
      c++;
    end
    chk(tag, c, 3);
  endtask

  // Called in RUN cycle 1; done is sampled in RUN cycle n; ends in NEXT.
  task automatic finish_layer(input int n);
    repeat (n - 1) tick;
    issue_done = 1'b1;
    tick;
    issue_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    num_layers = '0; start = 1'b0; issue_done = 1'b0;
    repeat (3) tick;
    chk("rst_issue_rst", issue_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dim", image_dim, 0);
    chk("rst_depth", image_depth, 0);
    chk("rst_half", filter_halfsize, 0);
    chk("rst_stride", filter_stride, 0);
    chk("rst_idx", layer_idx, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_error", error, 0);
    chk("rst_last", last_layer_cycles, 0);
    rst = 1'b0;
    tick;

    // Two-layer run, 100 RUN cycles each
    wr(3'd0, mk_desc(224, 3, 2, 4));
    wr(3'd1, mk_desc(55, 96, 2, 1));
    p0 = n_pulse;
    go(4'd2);
    chk("s1_busy_load", busy, 1);
    enter_run("s1_l0_rst_cycles");
    chk("s1_l0_dim", image_dim, 224);
    chk("s1_l0_depth", image_depth, 3);
    chk("s1_l0_half", filter_halfsize, 2);
    chk("s1_l0_stride", filter_stride, 4);
    chk("s1_l0_idx", layer_idx, 0);
    finish_layer(100);
    chk("s1_l0_last", last_layer_cycles, 100);
    tick;
    chk("s1_l1_idx_load", layer_idx, 1);
    chk("s1_dim_held_in_load", image_dim, 224);
    enter_run("s1_l1_rst_cycles");
    chk("s1_l1_dim", image_dim, 55);
    chk("s1_l1_depth", image_depth, 96);
    chk("s1_l1_half", filter_halfsize, 2);
    chk("s1_l1_stride", filter_stride, 1);
    finish_layer(100);
    chk("s1_l1_last", last_layer_cycles, 100);
    tick;
    chk("s1_all_done", all_done, 1);
    chk("s1_done_idx", layer_idx, 2);
    chk("s1_error", error, 0);
    tick;
    chk("s1_idle_all_done", all_done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_pulses", n_pulse - p0, 1);

    // Zero layers
    p0 = n_pulse; b0 = n_busy; r0 = n_run;
    go(4'd0);
    chk("s2_all_done", all_done, 1);
    chk("s2_busy", busy, 1);
    tick;
    chk("s2_all_done_off", all_done, 0);
    tick;
    chk("s2_busy_cycles", n_busy - b0, 1);
    chk("s2_pulses", n_pulse - p0, 1);
    chk("s2_run_cycles", n_run - r0, 0);

    // Invalid stride on layer 1
    wr(3'd1, mk_desc(224, 3, 2, 6));
    wr(3'd2, mk_desc(100, 10, 1, 3));
    p0 = n_pulse;
    go(4'd3);
    enter_run("s3_l0_rst_cycles");
    finish_layer(20);
    chk("s3_l0_last", last_layer_cycles, 20);
    tick;
    chk("s3_error_in_load", error, 0);
    chk("s3_idx_load", layer_idx, 1);
    tick;
    chk("s3_error_set", error, 1);
    chk("s3_all_done", all_done, 1);
    chk("s3_idx", layer_idx, 1);
    chk("s3_stride_loaded", filter_stride, 6);
    tick;
    chk("s3_error_sticky", error, 1);
    chk("s3_l2_not_loaded", image_dim, 224);
    chk("s3_pulses", n_pulse - p0, 1);

    // issue_done held across the layer boundary
    wr(3'd1, mk_desc(55, 96, 2, 1));
    p0 = n_pulse;
    go(4'd2);
    chk("s4_error_cleared", error, 0);
    enter_run("s4_l0_rst_cycles");
    repeat (9) tick;
    issue_done = 1'b1;
    tick;
    chk("s4_l0_last", last_layer_cycles, 10);
    tick;
    enter_run("s4_l1_rst_cycles");
    tick;
    chk("s4_stale_c2", issue_rst, 0);
    tick;
    chk("s4_stale_c3", issue_rst, 0);
    issue_done = 1'b0;
    tick;
    issue_done = 1'b1;
    tick;
    issue_done = 1'b0;
    chk("s4_l1_next", issue_rst, 1);
    chk("s4_l1_last", last_layer_cycles, 4);
    tick;
    chk("s4_all_done", all_done, 1);
    chk("s4_idx", layer_idx, 2);
    tick;
    chk("s4_pulses", n_pulse - p0, 1);

    // Reset during layer 1 RUN
    p0 = n_pulse;
    go(4'd2);
    enter_run("s5_l0_rst_cycles");
    finish_layer(5);
    tick;
    enter_run("s5_l1_rst_cycles");
    repeat (2) tick;
    rst = 1'b1;
    tick;
    chk("s5_busy", busy, 0);
    chk("s5_issue_rst", issue_rst, 1);
    chk("s5_idx", layer_idx, 0);
    chk("s5_all_done", all_done, 0);
    chk("s5_dim", image_dim, 0);
    rst = 1'b0;
    tick;
    chk("s5_no_pulse", n_pulse - p0, 0);

    // Fresh run; cfg_we and start during RUN are ignored
    p0 = n_pulse;
    go(4'd2);
    enter_run("s6_l0_rst_cycles");
    chk("s6_l0_dim", image_dim, 224);
    finish_layer(7);
    chk("s6_l0_last", last_layer_cycles, 7);
    tick;
    enter_run("s6_l1_rst_cycles");
    chk("s6_l1_dim", image_dim, 55);
    chk("s6_l1_depth", image_depth, 96);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = mk_desc(99, 9, 1, 1);
    num_layers = 4'd1; start = 1'b1;
    tick;
    cfg_we = 1'b0; start = 1'b0;
    chk("s6_start_ignored", issue_rst, 0);
    chk("s6_idx", layer_idx, 1);
    finish_layer(8);
    chk("s6_l1_last", last_layer_cycles, 9);
    tick;
    chk("s6_all_done", all_done, 1);
    chk("s6_done_idx", layer_idx, 2);
    tick;
    go(4'd1);
    enter_run("s7_rst_cycles");
    chk("s7_dim_intact", image_dim, 224);
    chk("s7_depth_intact", image_depth, 3);
    chk("s7_half_intact", filter_halfsize, 2);
    chk("s7_stride_intact", filter_stride, 4);
    finish_layer(3);
    chk("s7_last", last_layer_cycles, 3);
    tick;
    chk("s7_all_done", all_done, 1);
    chk("s7_idx", layer_idx, 1);
    tick;
    chk("s6_s7_pulses", n_pulse - p0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
